// File: rtl/led_pattern_engine.sv
// rtl/led_pattern_engine.sv - tick-driven LED pattern engine (shift/flash, optional ping-pong)
// Optional feature macro: LED_PATTERN_PINGPONG_EN enables the ping-pong (PP) mode.
module led_pattern_engine #(
   parameter int NB_LEDS = 4,
   parameter int NB_BTN  = 3
) (
   input  logic               clock,
   input  logic               i_reset,
   input  logic               i_valid,
   input  logic               i_enable,
   input  logic [NB_BTN-1:0]  i_btn,
   output logic [NB_LEDS-1:0] o_led,
   output logic [1:0]         o_state,
   output logic               o_dir
);

   typedef enum logic [1:0] {
      ST_SR = 2'b00,
      ST_FS = 2'b01,
      ST_PP = 2'b10
   } state_t;

   localparam logic [NB_LEDS-1:0] LED_LSB = {{(NB_LEDS-1){1'b0}}, 1'b1};
   localparam logic [NB_LEDS-1:0] LED_MSB = {1'b1, {(NB_LEDS-1){1'b0}}};

   state_t              state, state_next;
   logic [NB_LEDS-1:0]  led, led_next;
   logic                dir, dir_next;
   logic [NB_BTN-1:0]   btn_q;
   // Buttons already high during reset stay masked until seen low once,
   // so a button held across reset release never produces an edge.
   logic [NB_BTN-1:0]   stale;
   logic [NB_BTN-1:0]   edges;
   logic [NB_LEDS-1:0]  reload;

   assign edges  = i_btn & ~btn_q & ~stale;
   assign reload = dir ? LED_MSB : LED_LSB;

   // State register: mode, pattern, direction and button history
   always_ff @(posedge clock) begin
      if (i_reset) begin
         state <= ST_SR;
         led   <= LED_LSB;
         dir   <= 1'b0;
         btn_q <= '0;
         stale <= i_btn;
      end else begin
         state <= state_next;
         led   <= led_next;
         dir   <= dir_next;
         btn_q <= i_btn;
         stale <= stale & i_btn;
      end
   end

   // Next-state logic: highest-priority button edge wins, otherwise a tick advances
   always_comb begin
      state_next = state;
      led_next   = led;
      dir_next   = dir;
      if (i_enable) begin
         if (edges[0]) begin
`ifdef LED_PATTERN_PINGPONG_EN
            if (state == ST_SR) begin
               state_next = ST_PP;
            end else begin
               state_next = ST_SR;
               led_next   = reload;
            end
`else
            state_next = ST_SR;
            led_next   = reload;
`endif
         end else if (edges[1]) begin
            state_next = ST_FS;
            led_next   = '1;
         end else if (edges[2]) begin
            dir_next = ~dir;
         end else if (i_valid) begin
            case (state)
               ST_SR: begin
                  if (dir)
                     led_next = {led[0], led[NB_LEDS-1:1]};
                  else
                     led_next = {led[NB_LEDS-2:0], led[NB_LEDS-1]};
               end
               ST_FS: begin
                  led_next = ~led;
               end
`ifdef LED_PATTERN_PINGPONG_EN
               ST_PP: begin
                  if (!dir) begin
                     if (led[NB_LEDS-1]) begin
                        dir_next = 1'b1;
                        led_next = led >> 1;
                     end else begin
                        led_next = led << 1;
                     end
                  end else begin
                     if (led[0]) begin
                        dir_next = 1'b0;
                        led_next = led << 1;
                     end else begin
                        led_next = led >> 1;
                     end
                  end
               end
`endif
               default: begin
                  led_next = led;
               end
            endcase
         end
      end
   end

   // Outputs are driven straight from the registers
   always_comb begin
      o_led   = led;
      o_state = state;
      o_dir   = dir;
   end

endmodule

// File: tb/tb_led_pattern_engine.sv
// tb/tb_led_pattern_engine.sv - self-checking bench for led_pattern_engine
module tb_led_pattern_engine;
   localparam int N = 4;

   logic         clock;
   logic         i_reset;
   logic         i_valid;
   logic         i_enable;
   logic [2:0]   i_btn;
   logic [N-1:0] o_led;
   logic [1:0]   o_state;
   logic         o_dir;

   int checks = 0;
   int errors = 0;

   // reference model state: mode 0=SR 1=FS 2=PP, lit position, flash phase
   int         m_mode;
   int         m_pos;
   int         m_dir;
   int         m_fs;
   logic [2:0] m_prev;

   led_pattern_engine #(.NB_LEDS(N), .NB_BTN(3)) dut (
      .clock    (clock),
      .i_reset  (i_reset),
      .i_valid  (i_valid),
      .i_enable (i_enable),
      .i_btn    (i_btn),
      .o_led    (o_led),
      .o_state  (o_state),
      .o_dir    (o_dir)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [N-1:0] exp_led();
      if (m_mode == 1) return m_fs ? {N{1'b1}} : {N{1'b0}};
      return N'(1 << m_pos);
   endfunction

   function automatic void model_update(input logic rst, input logic en, input logic vld,
                                        input logic [2:0] btn);
      logic [2:0] e;
      if (rst) begin
         m_mode = 0; m_pos = 0; m_dir = 0; m_fs = 0;
         m_prev = btn;
         return;
      end
      e = btn & ~m_prev;
      m_prev = btn;
      if (!en) return;
      if (e[0]) begin
`ifdef LED_PATTERN_PINGPONG_EN
         if (m_mode == 0) begin
            m_mode = 2;
         end else begin
            m_mode = 0;
            m_pos = m_dir ? N - 1 : 0;
         end
`else
         m_mode = 0;
         m_pos = m_dir ? N - 1 : 0;
`endif
      end else if (e[1]) begin
         m_mode = 1; m_fs = 1;
      end else if (e[2]) begin
         m_dir = 1 - m_dir;
      end else if (vld) begin
         if (m_mode == 0) begin
            m_pos = m_dir ? (m_pos + N - 1) % N : (m_pos + 1) % N;
         end else if (m_mode == 1) begin
            m_fs = 1 - m_fs;
         end else begin
            if (m_dir == 0) begin
               if (m_pos == N - 1) begin m_dir = 1; m_pos = m_pos - 1; end
               else m_pos = m_pos + 1;
            end else begin
               if (m_pos == 0) begin m_dir = 0; m_pos = m_pos + 1; end
               else m_pos = m_pos - 1;
            end
         end
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step(input logic rst, input logic en, input logic vld, input logic [2:0] btn);
      i_reset  = rst;
      i_enable = en;
      i_valid  = vld;
      i_btn    = btn;
      @(posedge clock);
      #1;
      model_update(rst, en, vld, btn);
      chk("model_led", 32'(o_led), 32'(exp_led()));
      chk("model_state", 32'(o_state), 32'(m_mode));
      chk("model_dir", 32'(o_dir), 32'(m_dir));
   endtask

   logic [N-1:0] sr_seq [5];
   logic [N-1:0] pp_seq [7];
   logic         pp_dir [7];

   initial begin
      sr_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
      pp_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
      pp_dir = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      m_mode = 0; m_pos = 0; m_dir = 0; m_fs = 0; m_prev = '0;
      i_reset = 1'b1; i_enable = 1'b1; i_valid = 1'b0; i_btn = '0;

      // reset state
      step(1, 1, 0, 3'b000);
      chk("reset_led", 32'(o_led), 32'h1);
      chk("reset_state", 32'(o_state), 32'h0);
      chk("reset_dir", 32'(o_dir), 32'h0);

      // shift-register rotation with wrap
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 1, 3'b000);
         chk("sr_tick", 32'(o_led), 32'(sr_seq[i]));
      end
      chk("sr_state", 32'(o_state), 32'h0);

      // flash mode
      step(0, 1, 0, 3'b010);
      chk("fs_enter", 32'(o_led), 32'hF);
      chk("fs_state", 32'(o_state), 32'h1);
      step(0, 1, 0, 3'b000);
      step(0, 1, 1, 3'b000); chk("fs_tick1", 32'(o_led), 32'h0);
      step(0, 1, 1, 3'b000); chk("fs_tick2", 32'(o_led), 32'hF);
      step(0, 1, 1, 3'b000); chk("fs_tick3", 32'(o_led), 32'h0);
      step(0, 1, 0, 3'b100);
      chk("fs_dir", 32'(o_dir), 32'h1);
      chk("fs_dir_led", 32'(o_led), 32'h0);
      step(0, 1, 0, 3'b000);
      step(0, 1, 0, 3'b001);
      chk("reload_msb", 32'(o_led), 32'h8);
      chk("reload_state", 32'(o_state), 32'h0);
      step(0, 1, 0, 3'b000);
      step(0, 1, 1, 3'b000);
      chk("sr_right", 32'(o_led), 32'h4);

      // hold: ticks and a press while disabled are discarded
      for (int i = 0; i < 10; i++)
         step(0, 0, 1, (i == 3 || i == 4) ? 3'b010 : 3'b000);
      step(0, 1, 0, 3'b000);
      step(0, 1, 0, 3'b000);
      chk("hold_led", 32'(o_led), 32'h4);
      chk("hold_state", 32'(o_state), 32'h0);

      // same-cycle priority: bit0 wins, tick dropped
      step(0, 1, 0, 3'b100);
      step(0, 1, 0, 3'b000);
      step(0, 1, 1, 3'b011);
`ifdef LED_PATTERN_PINGPONG_EN
      chk("prio_led", 32'(o_led), 32'h4);
      chk("prio_state", 32'(o_state), 32'h2);
      step(0, 1, 0, 3'b000);
      step(0, 1, 0, 3'b001);
      chk("pp_exit_led", 32'(o_led), 32'h1);
      chk("pp_exit_state", 32'(o_state), 32'h0);
      step(0, 1, 0, 3'b000);
      step(0, 1, 0, 3'b001);
      chk("pp_enter_state", 32'(o_state), 32'h2);
      step(0, 1, 0, 3'b000);
      for (int i = 0; i < 7; i++) begin
         step(0, 1, 1, 3'b000);
         chk("pp_led", 32'(o_led), 32'(pp_seq[i]));
         chk("pp_dir", 32'(o_dir), 32'(pp_dir[i]));
      end
      step(0, 1, 0, 3'b001);
      step(0, 1, 0, 3'b000);
`else
      chk("prio_led", 32'(o_led), 32'h1);
      chk("prio_state", 32'(o_state), 32'h0);
      step(0, 1, 0, 3'b000);
`endif

      // reset from flash-dark, with bit1 held across reset release
      step(0, 1, 0, 3'b010);
      step(0, 1, 1, 3'b010);
      chk("fs_dark", 32'(o_led), 32'h0);
      step(1, 1, 0, 3'b010);
      chk("rst_fs_led", 32'(o_led), 32'h1);
      chk("rst_fs_state", 32'(o_state), 32'h0);
      chk("rst_fs_dir", 32'(o_dir), 32'h0);
      step(0, 1, 0, 3'b010);
      step(0, 1, 0, 3'b010);
      chk("held_no_fs", 32'(o_state), 32'h0);
      step(0, 1, 0, 3'b000);
      step(0, 1, 0, 3'b010);
      chk("repress_fs", 32'(o_state), 32'h1);

      // randomized phase against the reference model
      for (int i = 0; i < 600; i++) begin
         logic [2:0] b;
         b[0] = ($urandom_range(3) == 0);
         b[1] = ($urandom_range(5) == 0);
         b[2] = ($urandom_range(3) == 0);
         step(($urandom_range(49) == 0), ($urandom_range(7) != 0), 1'($urandom_range(1)), b);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
